// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch queue: request state machine
// encoding, instruction width and PC arithmetic helper.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT      = 2'd1,
        ST_WAIT_DROP = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fq_fifo.sv
// Synchronous FIFO holding {pc, instr} fetch entries; flush empties it in one edge.
module fq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues one outstanding memory read at a time and
// buffers returned {pc, instr} pairs for decode; redirect flushes and refetches.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc_plus4
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e             state;
    fetch_state_e             state_next;
    logic [31:0]              fetch_pc;
    logic [31:0]              fetch_pc_next;
    logic [31:0]              req_pc;
    logic [CNT_W-1:0]         count;
    logic [CNT_W-1:0]         occupancy;
    logic [2*INSTR_W-1:0]     head;
    logic                     pop;
    logic                     push;
    logic                     accept;

    assign inst_valid = (count != '0);
    assign pop        = inst_valid && !stall && !redirect;
    // Counting the entry leaving this cycle lets a full queue keep fetching.
    assign occupancy  = count - CNT_W'(pop);
    assign imem_req   = rst_n && (state == ST_IDLE) && (occupancy < CNT_W'(DEPTH));
    assign accept     = imem_req && imem_ready;
    assign push       = (state == ST_WAIT) && imem_rvalid && !redirect;
    assign imem_addr  = fetch_pc & ~32'h3;

    assign inst          = inst_valid ? head[INSTR_W-1:0] : '0;
    assign inst_pc       = inst_valid ? head[2*INSTR_W-1:INSTR_W] : '0;
    assign inst_pc_plus4 = pc_plus4(inst_pc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) req_pc <= imem_addr;
    end

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        case (state)
            ST_IDLE: begin
                // A redirect in the accepting cycle turns that request stale.
                if (accept) state_next = redirect ? ST_WAIT_DROP : ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_rvalid)   state_next = ST_IDLE;
                else if (redirect) state_next = ST_WAIT_DROP;
            end
            ST_WAIT_DROP: begin
                if (imem_rvalid) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (redirect)    fetch_pc_next = redirect_pc;
        else if (accept) fetch_pc_next = pc_plus4(imem_addr);
    end

    fq_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(2 * INSTR_W)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(redirect),
        .push (push),
        .pop  (pop),
        .wdata({req_pc, imem_rdata}),
        .rdata(head),
        .count(count)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic
// checked against a queue-based reference model and a variable-latency memory.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc_plus4;

    int errors = 0;
    int checks = 0;

    // Reference model: expected queue contents and fetch bookkeeping.
    logic [63:0] q[$];
    logic [31:0] m_fpc;
    logic [31:0] m_opc;
    bit          m_out;
    bit          m_drop;

    // Memory responder.
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;
    int          lat_lo = 1;
    int          lat_hi = 1;

    fetch_queue #(
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .stall        (stall),
        .inst_valid   (inst_valid),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .inst_pc_plus4(inst_pc_plus4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h2001_0005;
    endfunction

    task automatic model_reset();
        q.delete();
        m_fpc  = RESET_PC;
        m_opc  = '0;
        m_out  = 1'b0;
        m_drop = 1'b0;
    endtask

    // Called just after a falling edge; inputs settle before sampling.
    task automatic drive(input bit st, input bit rdy, input bit rd, input logic [31:0] rpc);
        stall       = st;
        imem_ready  = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        imem_rvalid = mem_busy && (mem_cnt == 1);
        imem_rdata  = imem_rvalid ? mdata(mem_addr) : 32'hDEAD_BEEF;
        #1;
    endtask

    task automatic tick();
        bit          pop;
        bit          req;
        bit          acc;
        logic [31:0] addr;
        @(posedge clk);
        pop  = (q.size() != 0) && !stall && !redirect;
        req  = !m_out && ((q.size() - int'(pop)) < DEPTH);
        acc  = req && imem_ready;
        addr = m_fpc & ~32'h3;
        if (redirect) begin
            q.delete();
            if (m_out) begin
                if (imem_rvalid) m_out = 1'b0;
                else             m_drop = 1'b1;
            end
            if (acc) begin
                m_out  = 1'b1;
                m_drop = 1'b1;
            end
            m_fpc = redirect_pc;
        end else begin
            if (pop) void'(q.pop_front());
            if (m_out && imem_rvalid) begin
                if (!m_drop) q.push_back({m_opc, imem_rdata});
                m_out = 1'b0;
            end
            if (acc) begin
                m_out  = 1'b1;
                m_drop = 1'b0;
                m_opc  = addr;
                m_fpc  = addr + 32'd4;
            end
        end
        if (imem_rvalid)   mem_busy = 1'b0;
        else if (mem_busy) mem_cnt--;
        if (acc) begin
            mem_busy = 1'b1;
            mem_addr = addr;
            mem_cnt  = $urandom_range(lat_hi, lat_lo);
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input bit clear_mem);
        rst_n       = 1'b0;
        stall       = 1'b0;
        imem_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        model_reset();
        if (clear_mem) mem_busy = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        stall       = 1'b0;
        imem_ready  = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        model_reset();
        mem_busy = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", inst_valid); end
        checks++; if (inst !== 32'h0) begin errors++; $display("FAIL rst_inst: got %h want 0", inst); end
        checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", inst_pc); end
        checks++; if (inst_pc_plus4 !== 32'h4) begin errors++; $display("FAIL rst_pc4: got %h want 4", inst_pc_plus4); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, '0);
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_rel_req: got %b want 1", imem_req); end
        checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL rst_rel_addr: got %h want %h", imem_addr, RESET_PC); end
        tick();
    endtask

    task automatic test_first_fetch();
        do_reset(1);
        lat_lo = 1; lat_hi = 1;
        drive(0, 1, 0, '0);
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL ff_addr: got %h want 0", imem_addr); end
        tick();
        drive(0, 0, 0, '0);
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL ff_early_valid: got %b want 0", inst_valid); end
        tick();
        drive(0, 0, 0, '0);
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL ff_valid: got %b want 1", inst_valid); end
        checks++; if (inst !== 32'h2001_0005) begin errors++; $display("FAIL ff_inst: got %h want 20010005", inst); end
        checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL ff_pc: got %h want 0", inst_pc); end
        checks++; if (inst_pc_plus4 !== 32'h4) begin errors++; $display("FAIL ff_pc4: got %h want 4", inst_pc_plus4); end
        tick();
    endtask

    task automatic test_stall_fill();
        do_reset(1);
        lat_lo = 1; lat_hi = 1;
        repeat (12) begin
            drive(1, 1, 0, '0);
            tick();
        end
        drive(1, 1, 0, '0);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL fill_req: got %b want 0", imem_req); end
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL fill_valid: got %b want 1", inst_valid); end
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 0, 0, '0);
            checks++; if (inst_pc !== 32'(4 * i)) begin errors++; $display("FAIL drain_pc[%0d]: got %h want %h", i, inst_pc, 32'(4 * i)); end
            checks++; if (inst !== mdata(32'(4 * i))) begin errors++; $display("FAIL drain_inst[%0d]: got %h want %h", i, inst, mdata(32'(4 * i))); end
            tick();
        end
        drive(1, 0, 0, '0);
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b want 0", inst_valid); end
        tick();
    endtask

    task automatic test_redirect_wait();
        do_reset(1);
        lat_lo = 2; lat_hi = 2;
        drive(0, 1, 0, '0);
        tick();
        drive(0, 0, 1, 32'h100);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rw_wait_req: got %b want 0", imem_req); end
        tick();
        lat_lo = 1; lat_hi = 1;
        drive(0, 0, 0, '0);
        checks++; if (imem_rvalid !== 1'b1) begin errors++; $display("FAIL rw_late_rvalid: got %b want 1", imem_rvalid); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rw_empty: got %b want 0", inst_valid); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rw_drop_req: got %b want 0", imem_req); end
        tick();
        drive(0, 1, 0, '0);
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rw_req: got %b want 1", imem_req); end
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL rw_addr: got %h want 100", imem_addr); end
        tick();
        drive(0, 0, 0, '0);
        tick();
        drive(1, 0, 0, '0);
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL rw_valid: got %b want 1", inst_valid); end
        checks++; if (inst_pc !== 32'h100) begin errors++; $display("FAIL rw_pc: got %h want 100", inst_pc); end
        tick();
    endtask

    task automatic test_redirect_rvalid();
        do_reset(1);
        lat_lo = 1; lat_hi = 1;
        repeat (5) begin
            drive(1, 1, 0, '0);
            tick();
        end
        drive(1, 1, 1, 32'h200);
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL rr_pre_valid: got %b want 1", inst_valid); end
        checks++; if (imem_rvalid !== 1'b1) begin errors++; $display("FAIL rr_rvalid: got %b want 1", imem_rvalid); end
        tick();
        drive(0, 0, 0, '0);
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rr_valid: got %b want 0", inst_valid); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rr_req: got %b want 1", imem_req); end
        checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL rr_addr: got %h want 200", imem_addr); end
        tick();
    endtask

    task automatic test_wrap();
        do_reset(1);
        lat_lo = 1; lat_hi = 1;
        drive(0, 0, 1, 32'hFFFF_FFFC);
        tick();
        drive(0, 1, 0, '0);
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr0: got %h want fffffffc", imem_addr); end
        tick();
        drive(0, 0, 0, '0);
        tick();
        drive(1, 1, 0, '0);
        checks++; if (inst_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc: got %h want fffffffc", inst_pc); end
        checks++; if (inst_pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4: got %h want 0", inst_pc_plus4); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL wrap_req: got %b want 1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr1: got %h want 0", imem_addr); end
        tick();
    endtask

    task automatic test_reset_wait();
        do_reset(1);
        lat_lo = 2; lat_hi = 2;
        drive(0, 1, 0, '0);
        tick();
        drive(0, 0, 0, '0);
        rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rwt_rst_req: got %b want 0", imem_req); end
        rst_n = 1'b1;
        model_reset();
        tick();
        drive(0, 0, 0, '0);
        checks++; if (imem_rvalid !== 1'b1) begin errors++; $display("FAIL rwt_late: got %b want 1", imem_rvalid); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rwt_req: got %b want 1", imem_req); end
        checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL rwt_addr: got %h want %h", imem_addr, RESET_PC); end
        tick();
        drive(1, 0, 0, '0);
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rwt_valid: got %b want 0", inst_valid); end
        tick();
    endtask

    task automatic test_random();
        bit          st;
        bit          rdy;
        bit          rd;
        logic [31:0] rpc;
        bit          exp_v;
        bit          exp_req;
        do_reset(1);
        lat_lo = 1; lat_hi = 3;
        for (int n = 0; n < 1500; n++) begin
            st  = ($urandom_range(99, 0) < 30);
            rdy = ($urandom_range(99, 0) < 65);
            rd  = ($urandom_range(99, 0) < 6);
            rpc = ($urandom_range(7, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom();
            drive(st, rdy, rd, rpc);
            exp_v   = (q.size() != 0);
            exp_req = !m_out && ((q.size() - int'(exp_v && !st && !rd)) < DEPTH);
            checks++;
            if (inst_valid !== exp_v) begin
                errors++; $display("FAIL rnd_valid @%0d: got %b want %b", n, inst_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if ({inst_pc, inst} !== q[0]) begin
                    errors++; $display("FAIL rnd_head @%0d: got %h_%h want %h", n, inst_pc, inst, q[0]);
                end
                checks++;
                if (inst_pc_plus4 !== q[0][63:32] + 32'd4) begin
                    errors++; $display("FAIL rnd_pc4 @%0d: got %h want %h", n, inst_pc_plus4, q[0][63:32] + 32'd4);
                end
            end
            checks++;
            if (imem_req !== exp_req) begin
                errors++; $display("FAIL rnd_req @%0d: got %b want %b", n, imem_req, exp_req);
            end
            if (exp_req) begin
                checks++;
                if (imem_addr !== (m_fpc & ~32'h3)) begin
                    errors++; $display("FAIL rnd_addr @%0d: got %h want %h", n, imem_addr, m_fpc & ~32'h3);
                end
            end
            tick();
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        stall       = 1'b0;
        imem_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        mem_busy    = 1'b0;
        mem_cnt     = 0;
        mem_addr    = '0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_first_fetch();
        test_stall_fill();
        test_redirect_wait();
        test_redirect_rvalid();
        test_wrap();
        test_reset_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
